fwd_hazard_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination-register metadata for instructions in EX, MEM and WB internally. At each ID→EX advance it registers the 2-bit select pairs that drive the two ALU-operand 4:1 forwarding muxes in EX. It also raises a one-cycle load-use stall and inserts a bubble when required.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/fwd_select.sv | 29 ++
 rtl/fwd_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes and the
// destination-register metadata carried by each tracked pipeline slot.
package pipe_pkg;

  // Slot rd storage width; module-level register addresses are zero-extended into it.
  localparam int unsigned META_RD_W = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_POST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [META_RD_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } dst_meta_t;

  // A slot produces a usable value for src; x0 is never forwarded.
  function automatic logic meta_match(input dst_meta_t m, input logic [META_RD_W-1:0] src);
    return m.valid && m.regwrite && (m.rd == src) && (m.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Nearest-first priority comparator for one source register against the
// EX/MEM/WB slots. FWD_WB_BYPASS_EN turns WB matches into the WB+1 select.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [META_RD_W-1:0] src,
  input  dst_meta_t            ex,
  input  dst_meta_t            mem,
  input  dst_meta_t            wb,
  output logic [1:0]           sel_c
);

  // Priority select: EX producer beats MEM beats WB.
  always_comb begin
    sel_c = FWD_RF;
    if (meta_match(ex, src)) begin
      sel_c = FWD_EXMEM;
    end else if (meta_match(mem, src)) begin
      sel_c = FWD_MEMWB;
    end else if (meta_match(wb, src)) begin
`ifdef FWD_WB_BYPASS_EN
      sel_c = FWD_POST;
`else
      sel_c = FWD_RF;
`endif
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks producer metadata in EX/MEM/WB, registers operand mux selects at
// each ID->EX advance, and raises a combinational load-use stall.
// Optional macro FWD_WB_BYPASS_EN adds a POST slot and the WB+1 select code.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HOLD,
  input  logic              FLUSH,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_REGWRITE,
  input  logic              ID_MEMREAD,
  output logic              STALL,
  output logic              FWD_A_S0,
  output logic              FWD_A_S1,
  output logic              FWD_B_S0,
  output logic              FWD_B_S1
);

  dst_meta_t ex_q;
  dst_meta_t mem_q;
  dst_meta_t wb_q;
`ifdef FWD_WB_BYPASS_EN
  dst_meta_t post_q;
`endif

  logic [1:0]           fwd_a_q;
  logic [1:0]           fwd_b_q;
  logic [1:0]           sel_a_c;
  logic [1:0]           sel_b_c;
  logic [META_RD_W-1:0] rs1_c;
  logic [META_RD_W-1:0] rs2_c;
  dst_meta_t            id_meta_c;
  logic                 load_use_c;
  logic                 bubble_c;

  // Widen ID fields into slot format.
  always_comb begin
    rs1_c              = META_RD_W'(ID_RS1);
    rs2_c              = META_RD_W'(ID_RS2);
    id_meta_c.valid    = ID_VALID;
    id_meta_c.rd       = META_RD_W'(ID_RD);
    id_meta_c.regwrite = ID_REGWRITE;
    id_meta_c.memread  = ID_MEMREAD;
  end

  fwd_select u_sel_a (
    .src   (rs1_c),
    .ex    (ex_q),
    .mem   (mem_q),
    .wb    (wb_q),
    .sel_c (sel_a_c)
  );

  fwd_select u_sel_b (
    .src   (rs2_c),
    .ex    (ex_q),
    .mem   (mem_q),
    .wb    (wb_q),
    .sel_c (sel_b_c)
  );

  // Load-use detection; FLUSH discards the consumer so it wins over the stall.
  always_comb begin
    load_use_c = ID_VALID && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                 (meta_match(ex_q, rs1_c) || meta_match(ex_q, rs2_c));
    bubble_c   = load_use_c || FLUSH || !ID_VALID;
    STALL      = load_use_c && !FLUSH && !RST;
  end

  // Slot shift and select registration; HOLD freezes everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
`ifdef FWD_WB_BYPASS_EN
      post_q  <= '0;
`endif
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!HOLD) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
`ifdef FWD_WB_BYPASS_EN
      post_q <= wb_q;
`endif
      if (bubble_c) begin
        ex_q    <= '0;
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        ex_q    <= id_meta_c;
        fwd_a_q <= sel_a_c;
        fwd_b_q <= sel_b_c;
      end
    end
  end

  assign FWD_A_S0 = fwd_a_q[0];
  assign FWD_A_S1 = fwd_a_q[1];
  assign FWD_B_S0 = fwd_b_q[0];
  assign FWD_B_S1 = fwd_b_q[1];

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: vector table with a select scoreboard queue,
// plus a hand-written reset-during-stall sequence.
module tb_fwd_hazard_ctrl;

`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] W = 2'b11;
`else
  localparam logic [1:0] W = 2'b00;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       HOLD;
  logic       FLUSH;
  logic       ID_VALID;
  logic [4:0] ID_RS1;
  logic [4:0] ID_RS2;
  logic [4:0] ID_RD;
  logic       ID_REGWRITE;
  logic       ID_MEMREAD;
  logic       STALL;
  logic       FWD_A_S0;
  logic       FWD_A_S1;
  logic       FWD_B_S0;
  logic       FWD_B_S1;

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .HOLD        (HOLD),
    .FLUSH       (FLUSH),
    .ID_VALID    (ID_VALID),
    .ID_RS1      (ID_RS1),
    .ID_RS2      (ID_RS2),
    .ID_RD       (ID_RD),
    .ID_REGWRITE (ID_REGWRITE),
    .ID_MEMREAD  (ID_MEMREAD),
    .STALL       (STALL),
    .FWD_A_S0    (FWD_A_S0),
    .FWD_A_S1    (FWD_A_S1),
    .FWD_B_S0    (FWD_B_S0),
    .FWD_B_S1    (FWD_B_S1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       hd;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  localparam int NV = 27;
  vec_t       tv [NV];
  logic [3:0] sb_q [$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic fl, input logic hd, input logic es,
                              input logic [1:0] ea, input logic [1:0] eb);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.mr = mr;
    t.fl = fl; t.hd = hd; t.es = es; t.ea = ea; t.eb = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ID_VALID = t.v; ID_RS1 = t.rs1; ID_RS2 = t.rs2; ID_RD = t.rd;
    ID_REGWRITE = t.rw; ID_MEMREAD = t.mr; FLUSH = t.fl; HOLD = t.hd;
  endtask

  function automatic logic [3:0] sels();
    return {FWD_A_S1, FWD_A_S0, FWD_B_S1, FWD_B_S0};
  endfunction

  initial begin
    logic [3:0] exp;
    // valid rs1 rs2 rd rw mr flush hold | stall A B
    tv[0]  = mk(1, 3, 4, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00);  // no producers
    tv[1]  = mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00);  // add x5
    tv[2]  = mk(1, 5, 6, 8, 1, 0, 0, 0, 0, 2'b01, 2'b10);  // EX and MEM forward
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);  // nop
    tv[4]  = mk(1, 8, 5, 0, 1, 0, 0, 0, 0, 2'b10, W);      // MEM and WB, writes x0
    tv[5]  = mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00); // read x0 not forwarded
    tv[6]  = mk(1, 10, 0, 7, 1, 1, 0, 0, 0, 2'b01, 2'b00); // lw x7
    tv[7]  = mk(1, 7, 10, 11, 1, 0, 0, 0, 1, 2'b00, 2'b00); // load-use stall
    tv[8]  = mk(1, 7, 10, 11, 1, 0, 0, 0, 0, 2'b10, W);    // replay after bubble
    tv[9]  = mk(1, 11, 7, 12, 1, 1, 0, 0, 0, 2'b01, W);    // lw x12
    tv[10] = mk(1, 3, 12, 13, 1, 0, 1, 0, 0, 2'b00, 2'b00); // flush beats stall
    tv[11] = mk(1, 12, 11, 14, 1, 0, 0, 0, 0, 2'b10, W);   // EX was a bubble
    tv[12] = mk(1, 14, 12, 15, 1, 0, 0, 1, 0, 2'b10, W);   // hold x3
    tv[13] = mk(1, 14, 12, 15, 1, 0, 0, 1, 0, 2'b10, W);
    tv[14] = mk(1, 14, 12, 15, 1, 0, 0, 1, 0, 2'b10, W);
    tv[15] = mk(1, 14, 12, 15, 1, 0, 0, 0, 0, 2'b01, W);   // resume
    tv[16] = mk(1, 0, 0, 16, 0, 0, 0, 0, 0, 2'b00, 2'b00); // non-writing producer
    tv[17] = mk(1, 16, 15, 17, 1, 0, 0, 0, 0, 2'b00, 2'b10);
    tv[18] = mk(1, 0, 0, 17, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    tv[19] = mk(1, 17, 17, 18, 1, 0, 0, 0, 0, 2'b01, 2'b01); // nearest wins
    tv[20] = mk(1, 0, 0, 20, 1, 1, 0, 0, 0, 2'b00, 2'b00); // lw x20
    tv[21] = mk(1, 1, 20, 21, 1, 0, 0, 0, 1, 2'b00, 2'b00); // stall via rs2
    tv[22] = mk(1, 1, 20, 21, 1, 0, 0, 0, 0, 2'b00, 2'b10);
    tv[23] = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00); // lw x0
    tv[24] = mk(1, 0, 0, 22, 1, 0, 0, 0, 0, 2'b00, 2'b00); // no stall on x0
    tv[25] = mk(1, 0, 0, 21, 1, 1, 0, 0, 0, 2'b00, 2'b00); // lw x21
    tv[26] = mk(0, 21, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00); // invalid ID, no stall

    RST = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_stall", {3'b000, STALL}, 4'b0000);
    chk("reset_sel", sels(), 4'b0000);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {3'b000, STALL}, {3'b000, tv[i].es});
      sb_q.push_back({tv[i].ea, tv[i].eb});
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 4'b0001, 4'b0000);
      end else begin
        exp = sb_q.pop_front();
        chk($sformatf("v%0d_sel", i), sels(), exp);
      end
    end

    // Reset pulse while a load-use stall is active.
    @(negedge CLK);
    drive(mk(1, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00));   // add x4
    @(negedge CLK);
    drive(mk(1, 4, 0, 9, 1, 1, 0, 0, 0, 2'b00, 2'b00));   // lw x9 uses x4
    @(posedge CLK);
    #1;
    chk("rst_pre_sel", sels(), 4'b0100);
    @(negedge CLK);
    drive(mk(1, 9, 0, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00));
    #1;
    chk("rst_pre_stall", {3'b000, STALL}, 4'b0001);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_mid_stall", {3'b000, STALL}, 4'b0000);
    chk("rst_mid_sel", sels(), 4'b0000);
    RST = 1'b0;
    #1;
    chk("rst_after_stall", {3'b000, STALL}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
